// File: rtl/seq_decoder38_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : seq_decoder38_pulse
//  Description : Buffers 3-bit codes in a 2-deep FIFO and replays each one as
//                a HOLD-cycle one-hot pulse followed by GAP idle cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_decoder38_pulse #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] Code,
  input  logic       Valid,
  output logic       Ready,
  input  logic       notEN,
  output logic [7:0] Output,
  output logic       Busy,
  output logic [1:0] Count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] c_hold_reload = 8'(HOLD - 1);
  localparam logic [7:0] c_gap_reload  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic       c_has_gap     = (GAP > 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic [2:0] fifo_q [2];
  logic [2:0] fifo_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  logic       w_push;
  logic       w_pop;
  logic       w_load;
  logic       w_avail;
  logic [2:0] w_head;

  // Ready looks only at registered occupancy, so a same-cycle pop never raises it.
  assign Ready   = ~Reset & ~notEN & (count_q != 2'd2);
  assign w_push  = Valid & Ready;
  assign w_avail = (count_q != 2'd0);
  assign w_head  = fifo_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    w_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_avail) begin
          w_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          if (c_has_gap) begin
            out_d   = 8'h00;
            state_d = ST_GAP;
            cnt_d   = c_gap_reload;
          end else if (w_avail) begin
            w_load = 1'b1;
          end else begin
            out_d   = 8'h00;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          if (w_avail) begin
            w_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 8'h00;
        cnt_d   = 8'd0;
      end
    endcase

    if (w_load) begin
      out_d   = 8'(1) << w_head;
      cnt_d   = c_hold_reload;
      state_d = ST_HOLD;
    end

    // Disable aborts any pulse in flight; nothing partial is resumed later.
    if (notEN) begin
      state_d = ST_IDLE;
      out_d   = 8'h00;
      cnt_d   = 8'd0;
      w_load  = 1'b0;
    end
  end

  assign w_pop = w_load;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (w_push) begin
      fifo_d[wr_ptr_q] = Code;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};

    if (notEN) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      out_q     <= 8'h00;
      fifo_q[0] <= 3'd0;
      fifo_q[1] <= 3'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign Output = out_q;
  assign Count  = count_q;
  assign Busy   = (state_q != ST_IDLE) | (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_seq_decoder38_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_decoder38_pulse
//  Description : Three differently parameterised decoders share one stimulus
//                stream and are compared against a pulse-schedule model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_decoder38_pulse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset = 1'b1;
  logic       notEN = 1'b0;
  logic       Valid = 1'b0;
  logic [2:0] Code  = 3'd0;

  logic [2:0]      rdy;
  logic [2:0]      busy;
  logic [2:0][7:0] outs;
  logic [2:0][1:0] cnts;
  logic [2:0]      rdy_pre;

  seq_decoder38_pulse #(.HOLD(4), .GAP(1)) u_d0 (
    .Clock(clk), .Reset(Reset), .Code(Code), .Valid(Valid), .Ready(rdy[0]),
    .notEN(notEN), .Output(outs[0]), .Busy(busy[0]), .Count(cnts[0]));
  seq_decoder38_pulse #(.HOLD(4), .GAP(0)) u_d1 (
    .Clock(clk), .Reset(Reset), .Code(Code), .Valid(Valid), .Ready(rdy[1]),
    .notEN(notEN), .Output(outs[1]), .Busy(busy[1]), .Count(cnts[1]));
  seq_decoder38_pulse #(.HOLD(1), .GAP(3)) u_d2 (
    .Clock(clk), .Reset(Reset), .Code(Code), .Valid(Valid), .Ready(rdy[2]),
    .notEN(notEN), .Output(outs[2]), .Busy(busy[2]), .Count(cnts[2]));

  int total = 0;
  int bad   = 0;

  // Model: a code queue plus "cycles of pulse left" and "zero cycles left".
  int         ha [3] = '{4, 4, 1};
  int         ga [3] = '{1, 0, 3};
  logic [2:0] mq [3][2];
  int         mc [3];
  int         mcur [3];
  int         mhold [3];
  int         mgap [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_out(input int d);
    return (mhold[d] > 0) ? 8'(1 << mcur[d]) : 8'h00;
  endfunction

  task automatic model_edge(input int d, input logic r, input logic n,
                            input logic v, input logic [2:0] c);
    logic push;
    logic start;
    if (r || n) begin
      mc[d] = 0; mhold[d] = 0; mgap[d] = 0;
    end else begin
      push  = v && (mc[d] < 2);
      start = 1'b0;
      if (mhold[d] > 1) mhold[d]--;
      else if (mhold[d] == 1) begin
        mhold[d] = 0;
        mgap[d]  = ga[d];
        if (ga[d] == 0 && mc[d] > 0) start = 1'b1;
      end else if (mgap[d] > 1) mgap[d]--;
      else begin
        mgap[d] = 0;
        if (mc[d] > 0) start = 1'b1;
      end
      if (start) begin
        mcur[d]  = int'(mq[d][0]);
        mq[d][0] = mq[d][1];
        mc[d]--;
        mhold[d] = ha[d];
      end
      if (push) begin
        mq[d][mc[d]] = c;
        mc[d]++;
      end
    end
  endtask

  task automatic step(input logic r, input logic n, input logic v, input logic [2:0] c);
    Reset = r; notEN = n; Valid = v; Code = c;
    #1;
    rdy_pre = rdy;
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(!r && !n && mc[d] < 2));
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d, r, n, v, c);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_out", d),   32'(outs[d]), 32'(m_out(d)));
      chk($sformatf("d%0d_count", d), 32'(cnts[d]), 32'(mc[d]));
      chk($sformatf("d%0d_busy", d),  32'(busy[d]),
          32'(mhold[d] > 0 || mgap[d] > 0 || mc[d] > 0));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  typedef struct {
    logic       rst, nen, valid;
    logic [2:0] code;
    logic       exp_ready;
    logic [7:0] exp_out;
    logic [1:0] exp_cnt;
    logic       exp_busy;
  } vec_t;

  vec_t vt [19];
  logic [7:0] exp_o;

  initial begin
    for (int d = 0; d < 3; d++) begin
      mc[d] = 0; mcur[d] = 0; mhold[d] = 0; mgap[d] = 0;
      mq[d][0] = 3'd0; mq[d][1] = 3'd0;
    end

    // Directed vectors for the HOLD=4 / GAP=1 instance: single code, then duplicates.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 2'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 8'h00, 2'd1, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h20, 2'd0, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h20, 2'd0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h20, 2'd0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h20, 2'd0, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 2'd0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 2'd0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h00, 2'd1, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h04, 2'd1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 2'd1, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 2'd1, 1'b1};
    vt[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 2'd1, 1'b1};
    vt[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 2'd1, 1'b1};
    vt[14] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 2'd0, 1'b1};
    vt[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 2'd0, 1'b1};
    vt[16] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 2'd0, 1'b1};
    vt[17] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h04, 2'd0, 1'b1};
    vt[18] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 2'd0, 1'b1};

    for (int i = 0; i < 19; i++) begin
      step(vt[i].rst, vt[i].nen, vt[i].valid, vt[i].code);
      chk($sformatf("vec%0d_ready", i), 32'(rdy_pre[0]), 32'(vt[i].exp_ready));
      chk($sformatf("vec%0d_out", i),   32'(outs[0]),    32'(vt[i].exp_out));
      chk($sformatf("vec%0d_count", i), 32'(cnts[0]),    32'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_busy", i),  32'(busy[0]),    32'(vt[i].exp_busy));
    end
    idle(2);
    chk("single_busy_clear", 32'(busy[0]), 32'd0);

    // GAP=0: pulses 0,7,2 abut with no zero cycle; Ready falls at Count==2.
    idle(30);
    step(1'b0, 1'b0, 1'b1, 3'd0);
    for (int k = 0; k < 13; k++) begin
      if (k == 0)      step(1'b0, 1'b0, 1'b1, 3'd7);
      else if (k == 1) step(1'b0, 1'b0, 1'b1, 3'd2);
      else             step(1'b0, 1'b0, 1'b0, 3'd0);
      if (k == 2) chk("b2b_ready_full", 32'(rdy_pre[1]), 32'd0);
      exp_o = (k < 4) ? 8'h01 : (k < 8) ? 8'h80 : (k < 12) ? 8'h04 : 8'h00;
      chk($sformatf("b2b_out%0d", k), 32'(outs[1]), 32'(exp_o));
    end

    // HOLD=1, GAP=3: 6 then 6 separated by exactly three zero cycles.
    idle(30);
    step(1'b0, 1'b0, 1'b1, 3'd6);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) step(1'b0, 1'b0, 1'b1, 3'd6);
      else        step(1'b0, 1'b0, 1'b0, 3'd0);
      exp_o = (k == 0 || k == 4) ? 8'h40 : 8'h00;
      chk($sformatf("gap_out%0d", k), 32'(outs[2]), 32'(exp_o));
    end

    // Full FIFO: code 4 offered while Count==2 must never appear.
    idle(30);
    step(1'b0, 1'b0, 1'b1, 3'd1);
    for (int k = 0; k < 16; k++) begin
      if (k == 0)      step(1'b0, 1'b0, 1'b1, 3'd2);
      else if (k == 1) step(1'b0, 1'b0, 1'b1, 3'd3);
      else if (k == 2) step(1'b0, 1'b0, 1'b1, 3'd4);
      else             step(1'b0, 1'b0, 1'b0, 3'd0);
      if (k == 1) chk("full_count2", 32'(cnts[0]), 32'd2);
      if (k == 2) chk("full_ready0", 32'(rdy_pre[0]), 32'd0);
      exp_o = (k < 4) ? 8'h02 : (k == 4) ? 8'h00 : (k < 9) ? 8'h04 :
              (k == 9) ? 8'h00 : (k < 14) ? 8'h08 : 8'h00;
      chk($sformatf("full_out%0d", k), 32'(outs[0]), 32'(exp_o));
    end

    // Disable on the 2nd hold cycle with one entry queued.
    idle(30);
    step(1'b0, 1'b0, 1'b1, 3'd4);
    for (int k = 0; k < 11; k++) begin
      case (k)
        0:       step(1'b0, 1'b0, 1'b1, 3'd3);
        2:       step(1'b0, 1'b1, 1'b0, 3'd0);
        3:       step(1'b0, 1'b1, 1'b1, 3'd5);
        4:       step(1'b0, 1'b0, 1'b1, 3'd1);
        default: step(1'b0, 1'b0, 1'b0, 3'd0);
      endcase
      if (k == 2 || k == 3) begin
        chk($sformatf("dis_ready%0d", k), 32'(rdy_pre[0]), 32'd0);
        chk($sformatf("dis_count%0d", k), 32'(cnts[0]), 32'd0);
      end
      exp_o = (k < 2) ? 8'h10 : (k >= 5 && k < 9) ? 8'h02 : 8'h00;
      chk($sformatf("dis_out%0d", k), 32'(outs[0]), 32'(exp_o));
    end

    // Reset while in the gap with the FIFO full.
    idle(30);
    step(1'b0, 1'b0, 1'b1, 3'd2);
    step(1'b0, 1'b0, 1'b1, 3'd5);
    step(1'b0, 1'b0, 1'b1, 3'd6);
    idle(3);
    chk("rst_pre_out", 32'(outs[0]), 32'h00);
    chk("rst_pre_count", 32'(cnts[0]), 32'd2);
    step(1'b1, 1'b0, 1'b0, 3'd0);
    chk("rst_ready_low", 32'(rdy_pre[0]), 32'd0);
    chk("rst_out", 32'(outs[0]), 32'h00);
    chk("rst_count", 32'(cnts[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0);
    chk("rst_ready_back", 32'(rdy_pre[0]), 32'd1);

    // Randomised traffic against the model for all three instances.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
